// File: rtl/data_ram_ctrl.sv
// Data-side RAM for the core's Mem stage: 32-bit words with byte-lane writes and a memory-mapped cycle counter.
// Optional macro DATA_RAM_MISALIGN_CHK_EN: misaligned accesses are suppressed and flagged on a sticky err_o.
module data_ram_ctrl #(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] CNT_ADDR = 32'h1FFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic        ce_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  datatype_sel_i,
    output logic [31:0] data_o,
    output logic        err_o
);

    localparam int unsigned DEPTH   = 1 << ADDR_W;
    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;

    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       r_cnt;

    logic [ADDR_W-1:0] w_idx;
    logic              w_is_cnt;
    logic              w_is_word;
    logic              w_mis;
    logic              w_rd;
    logic              w_wr;
    logic              w_cnt_ld;
    logic              w_ram_wr;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;

    assign w_idx     = addr_i[ADDR_W+1:2];
    assign w_is_cnt  = (addr_i == CNT_ADDR);
    // Reserved size 2'b11 behaves as a word access.
    assign w_is_word = datatype_sel_i[1];

`ifdef DATA_RAM_MISALIGN_CHK_EN
    assign w_mis = ((datatype_sel_i == SZ_HALF) && addr_i[0]) ||
                   (w_is_word && (addr_i[1:0] != 2'b00));
`else
    assign w_mis = 1'b0;
`endif

    assign w_rd     = ce_i & ~we_i & ~w_mis & ~rst;
    assign w_wr     = ce_i &  we_i & ~w_mis & ~rst;
    assign w_cnt_ld = w_wr & w_is_cnt & w_is_word;
    assign w_ram_wr = w_wr & ~w_is_cnt;

    // Store data is replicated across lanes so the enables alone select the target bytes.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = data_i;
        case (datatype_sel_i)
            SZ_BYTE: begin
                w_be    = 4'b0001 << addr_i[1:0];
                w_wdata = {4{data_i[7:0]}};
            end
            SZ_HALF: begin
                w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{data_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = data_i;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cnt_ld) begin
            r_cnt <= data_i;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    always_comb begin
        data_o = '0;
        if (w_rd) begin
            data_o = w_is_cnt ? r_cnt : r_mem[w_idx];
        end
    end

`ifdef DATA_RAM_MISALIGN_CHK_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (ce_i && w_mis) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Scoreboard bench for data_ram_ctrl: byte-array reference model feeds an expectation queue, a monitor checks data_o/err_o.
module tb_data_ram_ctrl;

    localparam int unsigned ADDR_W   = 10;
    localparam logic [31:0] CNT_ADDR = 32'h1FFF_FF00;
    localparam int unsigned NBYTES   = 4 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr_i = '0;
    logic        we_i = 1'b0;
    logic        ce_i = 1'b0;
    logic [31:0] data_i = '0;
    logic [1:0]  datatype_sel_i = 2'b10;
    logic [31:0] data_o;
    logic        err_o;

    data_ram_ctrl #(
        .ADDR_W   (ADDR_W),
        .CNT_ADDR (CNT_ADDR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .addr_i         (addr_i),
        .we_i           (we_i),
        .ce_i           (ce_i),
        .data_i         (data_i),
        .datatype_sel_i (datatype_sel_i),
        .data_o         (data_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  m_mem [NBYTES];
    logic [31:0] m_cnt = '0;
    logic        m_err = 1'b0;

    function automatic logic model_misaligned(input logic [31:0] a, input logic [1:0] sz);
`ifdef DATA_RAM_MISALIGN_CHK_EN
        if (sz == 2'b01) return a[0];
        if (sz[1])       return (a % 4) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // One bus cycle: inputs change 1 ns after the rising edge; model state advances across the edge.
    task automatic do_cycle(input logic ce, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [1:0] sz);
        int unsigned b;
        logic        mis;
        logic [31:0] nxt_cnt;
        exp_t        x;
        ce_i = ce; we_i = we; addr_i = a; data_i = d; datatype_sel_i = sz;
        b   = a % NBYTES;
        mis = model_misaligned(a, sz);
        if (!(ce && we)) begin
            x.d = '0;
            if (ce && !mis) begin
                if (a == CNT_ADDR) x.d = m_cnt;
                else begin
                    b = b - (b % 4);
                    x.d = {m_mem[b+3], m_mem[b+2], m_mem[b+1], m_mem[b]};
                end
            end
            x.e = m_err;
            exp_q.push_back(x);
        end
        nxt_cnt = m_cnt + 1;
        if (ce && mis) begin
            m_err = 1'b1;
        end else if (ce && we) begin
            if (a == CNT_ADDR) begin
                if (sz[1]) nxt_cnt = d;
            end else if (sz == 2'b00) begin
                m_mem[b] = d[7:0];
            end else if (sz == 2'b01) begin
                b = b - (b % 2);
                m_mem[b] = d[7:0]; m_mem[b+1] = d[15:8];
            end else begin
                b = b - (b % 4);
                for (int k = 0; k < 4; k++) m_mem[b+k] = d[8*k +: 8];
            end
        end
        m_cnt = nxt_cnt;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (!rst && !(ce_i && we_i)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: got output with no expectation at %0t", $time);
            end else begin
                x = exp_q.pop_front();
                check("data_o", data_o, x.d);
                check("err_o", {31'd0, err_o}, {31'd0, x.e});
            end
        end
    end

    initial begin
        logic [31:0] ra;
        logic [1:0]  rs;
        #3;
        check("reset_data_o", data_o, 32'h0);
        check("reset_err_o", {31'd0, err_o}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_cnt = '0; m_err = 1'b0;

        // Counter after reset release
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
        do_cycle(1'b1, 1'b0, CNT_ADDR, 32'h0, 2'b10);

        // Fill RAM so every later load has a defined expectation
        for (int i = 0; i < int'(1 << ADDR_W); i++)
            do_cycle(1'b1, 1'b1, 32'(i * 4), $urandom, 2'b10);

        // Directed byte-lane sequence
        do_cycle(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10);
        do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
        do_cycle(1'b1, 1'b1, 32'h12, 32'h000000AA, 2'b00);
        do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
        do_cycle(1'b1, 1'b1, 32'h10, 32'h00001234, 2'b01);
        do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
        do_cycle(1'b1, 1'b1, 32'h1010, 32'h11223344, 2'b10);
        do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 2'b10);

        // Counter load and wrap
        do_cycle(1'b1, 1'b1, CNT_ADDR, 32'hFFFF_FFFE, 2'b10);
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
        do_cycle(1'b1, 1'b0, CNT_ADDR, 32'h0, 2'b10);
        do_cycle(1'b1, 1'b0, CNT_ADDR, 32'h0, 2'b10);
        do_cycle(1'b1, 1'b1, CNT_ADDR, 32'h0000_1234, 2'b00);
        do_cycle(1'b1, 1'b0, CNT_ADDR, 32'h0, 2'b10);

        // ce gating
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 32'h10, 32'h0, 2'b10);
        do_cycle(1'b1, 1'b0, 32'h10, 32'h0, 2'b10);

        // Misaligned word store
        do_cycle(1'b1, 1'b1, 32'h21, 32'h55555555, 2'b10);
        do_cycle(1'b1, 1'b0, 32'h20, 32'h0, 2'b10);
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);

        // Randomized traffic, including aliases and counter-address hits
        for (int i = 0; i < 3000; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? CNT_ADDR
                 : {$urandom_range(0, 3) == 0 ? 20'($urandom) : 20'h0, 12'($urandom)};
            rs = 2'($urandom);
            do_cycle($urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1, ra, $urandom, rs);
        end

        // Reset asserted mid-operation during a load, store held across the edge
        ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h10; datatype_sel_i = 2'b10;
        #1;
        rst = 1'b1;
        #1;
        check("midreset_data_o", data_o, 32'h0);
        check("midreset_err_o", {31'd0, err_o}, 32'h0);
        we_i = 1'b1; addr_i = 32'h40; data_i = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1'b0;
        m_cnt = '0; m_err = 1'b0;
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);
        do_cycle(1'b1, 1'b0, CNT_ADDR, 32'h0, 2'b10);
        do_cycle(1'b1, 1'b0, 32'h40, 32'h0, 2'b10);
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 2'b10);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
